// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 command parser.
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IDX,
    S_C0,
    S_C1,
    S_C2,
    S_BCAST
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] BCAST_IDX_DEF = 8'hFF;
  localparam int         PKT_LEN       = 5;

endpackage

// File: rtl/ws2812_timeout_ctr.sv
// Inter-byte idle counter; saturates at LIMIT and flags expiry until cleared.
module ws2812_timeout_ctr #(
  parameter int LIMIT = 1200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             W       = $clog2(LIMIT + 1);
  localparam logic [W-1:0]   LIMIT_W = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (enable && (count != LIMIT_W))
      count <= count + 1'b1;
  end

  assign expired = (count == LIMIT_W);

endmodule

// File: rtl/ws2812_cmd_parser.sv
// Assembles sync/index/RGB byte packets into LED-memory writes, with broadcast
// fill, range checking and inter-byte timeout recovery.
module ws2812_cmd_parser
  import ws2812_pkg::*;
#(
  parameter int         NUM_LEDS       = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter logic [7:0] BCAST_IDX      = BCAST_IDX_DEF,
  parameter int         TIMEOUT_CYCLES = 1200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  led_num,
  output logic [23:0] rgb_data,
  output logic        write,
  output logic        busy,
  output logic        err_range,
  output logic        err_timeout
);

  localparam logic [7:0] NUM_LEDS_B = 8'(NUM_LEDS);
  localparam logic [7:0] LAST_LED   = 8'(NUM_LEDS - 1);

  state_t     state;
  logic [7:0] idx_q;
  logic [7:0] col0;
  logic [7:0] col1;
  logic [7:0] bcast_cnt;
  logic       accept;
  logic       in_packet;
  logic       expired;

  assign in_ready  = (state != S_BCAST);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign in_packet = (state == S_IDX) || (state == S_C0) ||
                     (state == S_C1)  || (state == S_C2);

  ws2812_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept || !in_packet),
    .enable  (in_packet),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      write       <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      led_num     <= '0;
      rgb_data    <= '0;
      idx_q       <= '0;
      col0        <= '0;
      col1        <= '0;
      bcast_cnt   <= '0;
    end else begin
      write       <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE))
            state <= S_IDX;
        end
        S_IDX, S_C0, S_C1, S_C2: begin
          // A byte arriving on the expiry cycle takes priority over the timeout.
          if (accept) begin
            case (state)
              S_IDX: begin
                idx_q <= in_data;
                state <= S_C0;
              end
              S_C0: begin
                col0  <= in_data;
                state <= S_C1;
              end
              S_C1: begin
                col1  <= in_data;
                state <= S_C2;
              end
              default: begin
                if (idx_q < NUM_LEDS_B) begin
                  write    <= 1'b1;
                  led_num  <= idx_q;
                  rgb_data <= {col0, col1, in_data};
                  state    <= S_IDLE;
                end else if (idx_q == BCAST_IDX) begin
                  write     <= 1'b1;
                  led_num   <= '0;
                  rgb_data  <= {col0, col1, in_data};
                  bcast_cnt <= '0;
                  state     <= S_BCAST;
                end else begin
                  err_range <= 1'b1;
                  state     <= S_IDLE;
                end
              end
            endcase
          end else if (expired) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_BCAST: begin
          if (bcast_cnt == LAST_LED) begin
            state <= S_IDLE;
          end else begin
            bcast_cnt <= bcast_cnt + 8'd1;
            led_num   <= bcast_cnt + 8'd1;
            write     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_cmd_parser.sv
// Directed bench for ws2812_cmd_parser: unicast, broadcast, range error,
// timeout recovery, garbage rejection and reset abort.
module tb_ws2812_cmd_parser;
  import ws2812_pkg::*;

  localparam int NUM_LEDS = 8;
  localparam int TIMEOUT  = 1200;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;
  logic        busy;
  logic        err_range;
  logic        err_timeout;

  int checks = 0;
  int passes = 0;
  int k;

  ws2812_cmd_parser #(
    .NUM_LEDS       (NUM_LEDS),
    .SYNC_BYTE      (8'hA5),
    .BCAST_IDX      (8'hFF),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .led_num     (led_num),
    .rgb_data    (rgb_data),
    .write       (write),
    .busy        (busy),
    .err_range   (err_range),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one byte for a single cycle; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_write", 32'(write), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_led_num", 32'(led_num), 0);
    checkOutput("rst_rgb", 32'(rgb_data), 0);
    checkOutput("rst_errs", 32'({err_range, err_timeout}), 0);
    reset = 1'b0;
    stepCycle();
    checkOutput("rst_in_ready", 32'(in_ready), 1);

    $display("[TB] unicast");
    applyStimulus(8'hA5);
    checkOutput("uni_busy_after_sync", 32'(busy), 1);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("uni_no_early_write", 32'(write), 0);
    applyStimulus(8'h33);
    checkOutput("uni_write", 32'(write), 1);
    checkOutput("uni_led_num", 32'(led_num), 3);
    checkOutput("uni_rgb", 32'(rgb_data), 32'h112233);
    checkOutput("uni_busy_done", 32'(busy), 0);
    stepCycle();
    checkOutput("uni_write_single", 32'(write), 0);
    checkOutput("uni_led_hold", 32'(led_num), 3);

    $display("[TB] broadcast");
    applyStimulus(8'hA5);
    applyStimulus(8'hFF);
    applyStimulus(8'h0A);
    applyStimulus(8'h0B);
    applyStimulus(8'h0C);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      checkOutput("bcast_write", 32'(write), 1);
      checkOutput("bcast_led_num", 32'(led_num), 32'(i));
      checkOutput("bcast_rgb", 32'(rgb_data), 32'h0A0B0C);
      checkOutput("bcast_in_ready", 32'(in_ready), 0);
      if (i < NUM_LEDS - 1) stepCycle();
    end
    in_valid = 1'b0;
    stepCycle();
    checkOutput("bcast_end_write", 32'(write), 0);
    checkOutput("bcast_byte_not_taken", 32'(busy), 0);
    checkOutput("bcast_end_ready", 32'(in_ready), 1);

    $display("[TB] range error");
    applyStimulus(8'hA5);
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("range_no_write", 32'(write), 0);
    checkOutput("range_err", 32'(err_range), 1);
    checkOutput("range_busy", 32'(busy), 0);
    stepCycle();
    checkOutput("range_err_single", 32'(err_range), 0);

    $display("[TB] timeout");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h44);
    k = 0;
    while (!err_timeout && k < 3 * TIMEOUT) begin
      stepCycle();
      k++;
    end
    checkOutput("to_latency", 32'(k), 32'(TIMEOUT + 1));
    checkOutput("to_err", 32'(err_timeout), 1);
    checkOutput("to_idle", 32'(busy), 0);
    stepCycle();
    checkOutput("to_err_single", 32'(err_timeout), 0);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    checkOutput("to_next_write", 32'(write), 1);
    checkOutput("to_next_led", 32'(led_num), 1);
    checkOutput("to_next_rgb", 32'(rgb_data), 32'hAABBCC);

    $display("[TB] byte on expiry cycle");
    applyStimulus(8'hA5);
    applyStimulus(8'h05);
    repeat (TIMEOUT) @(posedge clk);
    #1;
    applyStimulus(8'h01);
    checkOutput("edge_no_timeout", 32'(err_timeout), 0);
    checkOutput("edge_still_busy", 32'(busy), 1);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("edge_write", 32'(write), 1);
    checkOutput("edge_led", 32'(led_num), 5);
    checkOutput("edge_rgb", 32'(rgb_data), 32'h010203);

    $display("[TB] garbage then led 0");
    applyStimulus(8'h00);
    applyStimulus(8'h5A);
    checkOutput("garbage_idle", 32'(busy), 0);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    checkOutput("g_write", 32'(write), 1);
    checkOutput("g_led", 32'(led_num), 0);
    checkOutput("g_rgb", 32'(rgb_data), 32'hFFFFFF);

    $display("[TB] sync byte as data");
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    applyStimulus(8'hA5);
    checkOutput("sync_data_write", 32'(write), 1);
    checkOutput("sync_data_led", 32'(led_num), 2);
    checkOutput("sync_data_rgb", 32'(rgb_data), 32'hA5A5A5);

    $display("[TB] reset during broadcast");
    applyStimulus(8'hA5);
    applyStimulus(8'hFF);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    checkOutput("rb_first_write", 32'(write), 1);
    reset = 1'b1;
    stepCycle();
    checkOutput("rb_write_killed", 32'(write), 0);
    checkOutput("rb_idle", 32'(busy), 0);
    reset = 1'b0;
    stepCycle();
    checkOutput("rb_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < NUM_LEDS; i++) begin
      checkOutput("rb_no_write", 32'(write), 0);
      stepCycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
